// File: rtl/frame_average_ctrl.sv
// ============================================================================
// Module      : frame_average_ctrl
// Description : Sequencer for the frame-delay FIFO and recursive average filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_average_ctrl #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 10,
  parameter int USEDW_WIDTH  = 13,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   sink_valid,
  input  logic                   sink_sop,
  input  logic                   sink_eop,
  input  logic [USEDW_WIDTH-1:0] fifo_usedw,
  output logic                   fifo_wrreq,
  output logic                   fifo_rdreq,
  output logic                   fifo_sclr,
  output logic                   sel_bypass,
  output logic                   avg_valid,
  output logic                   frame_err,
  output logic                   primed,
  output logic [CNT_WIDTH-1:0]   pix_x,
  output logic [CNT_WIDTH-1:0]   line_y
);

  localparam logic [CNT_WIDTH-1:0]   C_LAST_X     = CNT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0]   C_LAST_Y     = CNT_WIDTH'(FRAME_HEIGHT - 1);
  localparam logic [USEDW_WIDTH-1:0] C_USEDW_FULL = USEDW_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   primed_q;
  logic                   frame_err_q;
  logic [CNT_WIDTH-1:0]   pix_x_q;
  logic [CNT_WIDTH-1:0]   line_y_q;

  logic last_x;
  logic at_last;
  logic bad_beat;

  assign last_x  = (pix_x_q == C_LAST_X);
  assign at_last = last_x && (line_y_q == C_LAST_Y);
  // A stray sop, an early eop, or a missing eop all corrupt the delay line.
  assign bad_beat = sink_sop || (sink_eop != at_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      primed_q    <= 1'b0;
      frame_err_q <= 1'b0;
      pix_x_q     <= '0;
      line_y_q    <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sink_valid && sink_sop && en) begin
            pix_x_q  <= CNT_WIDTH'(1);
            line_y_q <= '0;
            if (!primed_q) begin
              state_q <= S_PRIME;
            end else if (fifo_usedw == C_USEDW_FULL) begin
              state_q <= S_RUN;
            end else begin
              frame_err_q <= 1'b1;
              primed_q    <= 1'b0;
              pix_x_q     <= '0;
              state_q     <= S_FLUSH;
            end
          end
        end
        S_PRIME, S_RUN: begin
          if (sink_valid) begin
            if (bad_beat) begin
              frame_err_q <= 1'b1;
              primed_q    <= 1'b0;
              pix_x_q     <= '0;
              line_y_q    <= '0;
              state_q     <= S_FLUSH;
            end else if (at_last) begin
              if (state_q == S_PRIME) primed_q <= 1'b1;
              pix_x_q  <= '0;
              line_y_q <= '0;
              state_q  <= S_IDLE;
            end else if (last_x) begin
              pix_x_q  <= '0;
              line_y_q <= line_y_q + CNT_WIDTH'(1);
            end else begin
              pix_x_q <= pix_x_q + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo_wrreq = sink_valid && ((state_q == S_PRIME) || (state_q == S_RUN));
  assign fifo_rdreq = sink_valid && (state_q == S_RUN);
  assign avg_valid  = sink_valid && (state_q == S_RUN);
  assign sel_bypass = (state_q != S_RUN);
  assign fifo_sclr  = reset || (state_q == S_FLUSH);
  assign frame_err  = frame_err_q;
  assign primed     = primed_q;
  assign pix_x      = pix_x_q;
  assign line_y     = line_y_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_average_ctrl.sv
// ============================================================================
// Module      : tb_frame_average_ctrl
// Description : Directed self-checking bench for frame_average_ctrl (4x2 frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_average_ctrl;

  localparam int FW = 4;
  localparam int FH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        sink_valid = 1'b0;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [12:0] fifo_usedw = '0;
  logic        fifo_wrreq, fifo_rdreq, fifo_sclr, sel_bypass, avg_valid, frame_err, primed;
  logic [9:0]  pix_x, line_y;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr = 0, n_rd = 0, n_avg = 0, n_byp = 0, n_err = 0, n_sclr = 0;
  int s_wr, s_rd, s_avg, s_byp, s_err, s_sclr;

  frame_average_ctrl #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .USEDW_WIDTH (13),
    .CNT_WIDTH   (10)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sink_valid(sink_valid),
    .sink_sop  (sink_sop),
    .sink_eop  (sink_eop),
    .fifo_usedw(fifo_usedw),
    .fifo_wrreq(fifo_wrreq),
    .fifo_rdreq(fifo_rdreq),
    .fifo_sclr (fifo_sclr),
    .sel_bypass(sel_bypass),
    .avg_valid (avg_valid),
    .frame_err (frame_err),
    .primed    (primed),
    .pix_x     (pix_x),
    .line_y    (line_y)
  );

  always #5 clk = ~clk;

  // Strobe tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (fifo_wrreq)               n_wr   <= n_wr + 1;
    if (fifo_rdreq)               n_rd   <= n_rd + 1;
    if (avg_valid)                n_avg  <= n_avg + 1;
    if (fifo_wrreq && sel_bypass) n_byp  <= n_byp + 1;
    if (frame_err)                n_err  <= n_err + 1;
    if (fifo_sclr)                n_sclr <= n_sclr + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input bit v, input bit s, input bit e);
    @(posedge clk);
    #1;
    sink_valid = v;
    sink_sop   = s;
    sink_eop   = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic snap;
    s_wr = n_wr; s_rd = n_rd; s_avg = n_avg; s_byp = n_byp; s_err = n_err; s_sclr = n_sclr;
  endtask

  // Sends n beats with sop on beat 1 and eop on beat eop_at (0 = none).
  task automatic send_frame(input int n, input int eop_at, input bit gaps);
    for (int i = 1; i <= n; i++) begin
      drive(1'b1, i == 1, i == eop_at);
      if (gaps) begin
        drive(1'b0, 1'b0, 1'b0);
        if (i == 4) begin
          chk("gap_line_y", int'(line_y), 1);
          chk("gap_pix_x", int'(pix_x), 0);
        end
      end
    end
    idle(2);
  endtask

  task automatic chk_frame(input string tag, input int wr, input int rd, input int byp,
                           input int err, input int pr);
    chk({tag, "_wr"},  n_wr - s_wr, wr);
    chk({tag, "_rd"},  n_rd - s_rd, rd);
    chk({tag, "_avg"}, n_avg - s_avg, rd);
    chk({tag, "_byp"}, n_byp - s_byp, byp);
    chk({tag, "_err"}, n_err - s_err, err);
    chk({tag, "_sclr"}, n_sclr - s_sclr, err);
    chk({tag, "_primed"}, int'(primed), pr);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclr", int'(fifo_sclr), 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_primed", int'(primed), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_line_y", int'(line_y), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_bypass", int'(sel_bypass), 1);
    chk("rst_wrreq", int'(fifo_wrreq), 0);
    chk("rst_sclr_off", int'(fifo_sclr), 0);

    // Priming frame: sop not written, 7 bypass writes, no reads.
    snap; send_frame(8, 8, 1'b0);
    chk_frame("prime", 7, 0, 7, 0, 1);
    chk("prime_pix_x", int'(pix_x), 0);
    chk("prime_line_y", int'(line_y), 0);

    // Steady-state frame with a full delay line.
    fifo_usedw = 13'd7;
    snap; send_frame(8, 8, 1'b0);
    chk_frame("run", 7, 7, 0, 0, 1);

    // Beats separated by idle cycles: same strobe totals.
    snap; send_frame(8, 8, 1'b1);
    chk_frame("gap", 7, 7, 0, 0, 1);

    // Early eop on beat 6 -> error, flush, unprimed; next frame re-primes.
    snap; send_frame(6, 6, 1'b0);
    chk_frame("early_eop", 5, 5, 0, 1, 0);
    snap; send_frame(8, 8, 1'b0);
    chk_frame("reprime", 7, 0, 7, 0, 1);

    // Second sop inside a RUN frame.
    snap;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    idle(2);
    chk_frame("mid_sop", 3, 3, 0, 1, 0);
    chk("mid_sop_pix_x", int'(pix_x), 0);
    snap; send_frame(8, 8, 1'b0);
    chk_frame("reprime2", 7, 0, 7, 0, 1);

    // Wrong fill level at a RUN sop.
    fifo_usedw = 13'd5;
    snap; send_frame(1, 0, 1'b0);
    chk_frame("bad_usedw", 0, 0, 0, 1, 0);
    fifo_usedw = 13'd7;
    snap; send_frame(8, 8, 1'b0);
    chk_frame("reprime3", 7, 0, 7, 0, 1);

    // Reset asserted on beat 3 of a RUN frame.
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_sclr", int'(fifo_sclr), 1);
    chk("midrst_wrreq", int'(fifo_wrreq), 0);
    chk("midrst_rdreq", int'(fifo_rdreq), 0);
    chk("midrst_avg", int'(avg_valid), 0);
    chk("midrst_bypass", int'(sel_bypass), 1);
    chk("midrst_primed", int'(primed), 0);
    chk("midrst_pix_x", int'(pix_x), 0);
    chk("midrst_line_y", int'(line_y), 0);
    chk("midrst_err", int'(frame_err), 0);
    sink_valid = 1'b0;
    reset = 1'b0;
    idle(1);

    // en low at sop ignores the frame; en high re-enters normally.
    en = 1'b0;
    snap; send_frame(8, 8, 1'b0);
    chk_frame("en_off", 0, 0, 0, 0, 0);
    en = 1'b1;
    snap; send_frame(8, 8, 1'b0);
    chk_frame("en_on", 7, 0, 7, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
